sincos_post_encode: RTL and testbench
=====================================

// Module: sincos_post_encode
// PURPOSE
//  Output-side counterpart of the pre-map decode stage. It takes the core's fixed-point sin/cos magnitude plus
//  the decode-side case flags, and re-encodes the result as an IEEE-754 single.
//  Results are produced on special-case paths: exact zero, cos~1, and sin(x)~x pass-through.
//  The normal path normalises and rounds the magnitude (round-to-nearest-even).
//  Sits between the CORDIC/table core and the top-level result port. It is a 3-stage valid/ready pipeline.
// PARAMETERS
//  MAG_W     33   width of core magnitude, unsigned Q1.(MAG_W-1)
//  EXP_BIAS  127  IEEE-754 single exponent bias
// PORTS
//  i_clk              in   1   clock
//  i_rst_n            in   1   reset, synchronous, active-low
//  i_valid            in   1   input beat valid
//  o_ready            out  1   block accepts beat this cycle
//  i_x                in   32  original float operand (used for pass-through and sign of zero)
//  i_sincos_proced    in   1   0 = sin, 1 = cos
//  i_X_APPRO_ZERO     in   1   |x| < 2^-19 (from decode stage)
//  i_X_ZERO_CAL_FLAG  in   1   exact-result case (from decode stage)
//  i_res_sign         in   1   sign of core result
//  i_res_mag          in   MAG_W  core magnitude, value = i_res_mag * 2^-(MAG_W-1)
//  o_valid            out  1   output beat valid
//  i_ready            in   1   downstream accepts
//  o_result           out  32  IEEE-754 single result
//  o_special          out  1   result came from a special-case path
// BEHAVIOUR
//  Clocking and reset
//   - Interface: one clock (i_clk); reset is synchronous and active-low (i_rst_n).
//   - While i_rst_n==0: all stage valids=0, o_valid=0, o_result=0, o_special=0, o_ready=0.
//   - Reset mid-stream discards every in-flight beat; no partial output appears afterwards.
//  Handshake
//   - A beat transfers on i_valid&o_ready (input side) and on o_valid&i_ready (output side).
//   - Stage k advances when stage k+1 is empty or is itself advancing; bubbles collapse.
//   - o_ready = !s1_valid | s1_adv. A combinational i_ready->o_ready path is permitted.
//   - o_result and o_special are held stable while o_valid & !i_ready.
//   - Order is preserved and no beat is dropped or duplicated.
//  Latency
//   - 3 cycles from accepted input to o_valid when unstalled.
//   - Throughput is 1 beat/cycle.
//  S1 (capture / classify), priority high->low:
//   - ZERO_CAL & cos -> 32'h3F80_0000.
//   - ZERO_CAL & sin -> {i_x[31],31'b0}.
//   - APPRO_ZERO & sin -> i_x unchanged.
//   - All three set o_special=1. Otherwise take the normal path and latch sign/mag.
//   - APPRO_ZERO & cos always co-occurs with ZERO_CAL, so it is covered by the first case.
//  S2 (leading-zero count)
//   - p = index of the leading one of mag.
//   - mag==0 -> result {res_sign,31'b0}, o_special=0.
//  S3 (shift / round / pack)
//   - Left-align mag so bit p lands at bit MAG_W-1.
//   - mantissa = next 23 bits; guard = following bit; sticky = OR of the rest.
//   - Round up iff guard & (sticky | mant_lsb).
//   - Biased exponent = EXP_BIAS-(MAG_W-1)+p, i.e. 95+p for MAG_W=33.
//   - Mantissa carry-out -> mantissa=0, exponent+1.
//   - p>=0 guarantees exponent>=95, so no denormal or overflow handling is required.
//   - o_result = {res_sign, exp[7:0], mant[22:0]}.
// STRUCTURE
//  - Shared package sincos_pkg: EXP_BIAS, MAG_W, FP_ONE=32'h3F80_0000, SEL_SIN/SEL_COS encodings.
//  - One sub-module: sincos_lzc (parameterised leading-zero counter, purely combinational), used in S2.
//  - Stage registers and handshake logic stay in this module.
// TESTING
//  1. ZERO_CAL=1, cos, i_x=32'h0000_0000 -> o_result=32'h3F80_0000, o_special=1, 3 cycles later.
//  2. APPRO_ZERO=1, sin, i_x=32'hB300_0000 -> o_result=32'hB300_0000, o_special=1.
//  3. mag=33'h1_0000_0000, sign=0 -> 32'h3F80_0000.
//     mag=33'h0_8000_0000, sign=1 -> 32'hBF00_0000.
//  4. Rounding:
//     mag=33'h0_FFFF_FFFF -> rounds up with carry -> 32'h3F80_0000.
//     mag=33'h1_0000_0100 (tie, lsb 0) -> 32'h3F80_0000.
//     mag=33'h1_0000_0300 (tie, lsb 1) -> 32'h3F80_0002.
//  5. Back-to-back: 6 beats with i_ready low for cycles 4-8 -> all 6 emerge in order.
//     o_result is held stable while stalled; o_ready drops once the pipe is full.
//  6. i_rst_n=0 for 1 cycle with 3 beats in flight -> o_valid=0 next cycle and the old beats never appear.
//     The next accepted beat emerges after 3 cycles.

Source files
------------

// File: rtl/sincos_pkg.sv
// Shared constants, encodings and helpers for the sin/cos post-encode stage.
// Imported by the post-encode pipeline and its leading-zero counter.
package sincos_pkg;

  localparam int SC_MAG_W    = 33;
  localparam int SC_EXP_BIAS = 127;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  localparam logic SEL_SIN = 1'b0;
  localparam logic SEL_COS = 1'b1;

  // Which S1 path produced the beat
  typedef enum logic [1:0] {
    PATH_NORMAL      = 2'd0,
    PATH_ONE         = 2'd1,
    PATH_SIGNED_ZERO = 2'd2,
    PATH_PASS        = 2'd3
  } path_e;

  function automatic logic [31:0] pack_fp(input logic        sign,
                                          input logic [7:0]  exp,
                                          input logic [22:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/sincos_lzc.sv
// Parameterised combinational leading-zero counter.
// An all-zero input reports count=W and raises zero.
module sincos_lzc #(
  parameter int W     = 33,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CNT_W'(W - 1 - i);
    end
  end

  assign zero = ~|value;

endmodule

// File: rtl/sincos_post_encode.sv
// Re-encodes the sin/cos core magnitude as an IEEE-754 single.
// Three-stage valid/ready pipeline: classify, leading-zero count, shift/round/pack.
module sincos_post_encode
  import sincos_pkg::*;
#(
  parameter int MAG_W    = SC_MAG_W,
  parameter int EXP_BIAS = SC_EXP_BIAS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_x,
  input  logic             i_sincos_proced,
  input  logic             i_X_APPRO_ZERO,
  input  logic             i_X_ZERO_CAL_FLAG,
  input  logic             i_res_sign,
  input  logic [MAG_W-1:0] i_res_mag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic             o_special
);

  localparam int LZC_W     = $clog2(MAG_W + 1);
  localparam int GUARD_BIT = MAG_W - 25;

  // Handshake
  logic s1_valid, s2_valid, s3_valid;
  logic s3_free, s2_free, s1_free;
  logic in_fire;

  assign s3_free = !s3_valid || i_ready;
  assign s2_free = !s2_valid || s3_free;
  assign s1_free = !s1_valid || s2_free;
  assign o_ready = i_rst_n && s1_free;
  assign in_fire = i_valid && o_ready;

  // S1: classify
  path_e       path;
  logic [31:0] special_result;

  always_comb begin
    path = PATH_NORMAL;
    if (i_X_ZERO_CAL_FLAG && (i_sincos_proced == SEL_COS)) begin
      path = PATH_ONE;
    end else if (i_X_ZERO_CAL_FLAG) begin
      path = PATH_SIGNED_ZERO;
    end else if (i_X_APPRO_ZERO && (i_sincos_proced == SEL_SIN)) begin
      path = PATH_PASS;
    end
  end

  always_comb begin
    special_result = 32'h0;
    case (path)
      PATH_ONE:         special_result = FP_ONE;
      PATH_SIGNED_ZERO: special_result = {i_x[31], 31'b0};
      PATH_PASS:        special_result = i_x;
      default:          special_result = 32'h0;
    endcase
  end

  logic             s1_special;
  logic [31:0]      s1_result;
  logic             s1_sign;
  logic [MAG_W-1:0] s1_mag;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_special <= 1'b0;
      s1_result  <= 32'h0;
      s1_sign    <= 1'b0;
      s1_mag     <= '0;
    end else if (s1_free) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_special <= (path != PATH_NORMAL);
        s1_result  <= special_result;
        s1_sign    <= i_res_sign;
        s1_mag     <= i_res_mag;
      end
    end
  end

  // S2: leading-zero count
  logic [LZC_W-1:0] lzc_count;
  logic             lzc_zero;

  sincos_lzc #(
    .W     (MAG_W),
    .CNT_W (LZC_W)
  ) u_lzc (
    .value (s1_mag),
    .count (lzc_count),
    .zero  (lzc_zero)
  );

  logic             s2_special;
  logic             s2_final;
  logic [31:0]      s2_result;
  logic             s2_sign;
  logic [MAG_W-1:0] s2_mag;
  logic [LZC_W-1:0] s2_lzc;

  // A zero magnitude is finished here as a signed zero but is not a special path.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid   <= 1'b0;
      s2_special <= 1'b0;
      s2_final   <= 1'b0;
      s2_result  <= 32'h0;
      s2_sign    <= 1'b0;
      s2_mag     <= '0;
      s2_lzc     <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_special <= s1_special;
        s2_final   <= s1_special || lzc_zero;
        s2_result  <= s1_special ? s1_result : {s1_sign, 31'b0};
        s2_sign    <= s1_sign;
        s2_mag     <= s1_mag;
        s2_lzc     <= lzc_count;
      end
    end
  end

  // S3: shift / round / pack. The leading one is dropped by the truncating cast.
  logic [MAG_W-2:0] frac;
  logic [22:0]      mant;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [23:0]      mant_rnd;
  logic [7:0]       exp_base;
  logic [7:0]       exp_fin;
  logic [31:0]      s3_next;

  assign frac     = (MAG_W-1)'(s2_mag << s2_lzc);
  assign mant     = frac[MAG_W-2 -: 23];
  assign guard    = frac[GUARD_BIT];
  assign sticky   = |frac[GUARD_BIT-1:0];
  assign round_up = guard && (sticky || mant[0]);
  assign mant_rnd = {1'b0, mant} + {23'd0, round_up};
  // EXP_BIAS-(MAG_W-1)+p with p = MAG_W-1-lzc collapses to EXP_BIAS-lzc
  assign exp_base = 8'(EXP_BIAS - int'(s2_lzc));
  assign exp_fin  = exp_base + {7'd0, mant_rnd[23]};
  assign s3_next  = s2_final ? s2_result : pack_fp(s2_sign, exp_fin, mant_rnd[22:0]);

  logic [31:0] s3_result;
  logic        s3_special;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s3_valid   <= 1'b0;
      s3_result  <= 32'h0;
      s3_special <= 1'b0;
    end else if (s3_free) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_result  <= s3_next;
        s3_special <= s2_special;
      end
    end
  end

  assign o_valid   = s3_valid;
  assign o_result  = s3_result;
  assign o_special = s3_special;

endmodule

// File: tb/tb_sincos_post_encode.sv
// Directed self-checking bench for sincos_post_encode.
module tb_sincos_post_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        proced;
  logic        appro;
  logic        zcal;
  logic        sign;
  logic [32:0] mag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        special;

  int total = 0;
  int bad   = 0;

  sincos_post_encode dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_valid           (in_valid),
    .o_ready           (in_ready),
    .i_x               (x),
    .i_sincos_proced   (proced),
    .i_X_APPRO_ZERO    (appro),
    .i_X_ZERO_CAL_FLAG (zcal),
    .i_res_sign        (sign),
    .i_res_mag         (mag),
    .o_valid           (out_valid),
    .i_ready           (out_ready),
    .o_result          (result),
    .o_special         (special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_beat(input logic [31:0] bx, input logic bp, input logic ba,
                          input logic bz, input logic bs, input logic [32:0] bm);
    x = bx; proced = bp; appro = ba; zcal = bz; sign = bs; mag = bm;
  endtask

  // Sends the currently set beat into an empty pipe and waits for it to emerge.
  task automatic run_one(output logic [31:0] res, output logic spec, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res  = result;
    spec = special;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    set_beat(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 33'h1_0000_0000);
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    total++; if (special !== 1'b0) begin bad++; $display("FAIL reset_special got=%b want=0", special); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_special();
    logic [31:0] r; logic s; int lat;
    set_beat(32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 33'h0_1234_5678);
    run_one(r, s, lat);
    total++; if (r !== 32'h3F80_0000) begin bad++; $display("FAIL zcal_cos got=%h want=3f800000", r); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL zcal_cos_special got=%b want=1", s); end
    total++; if (lat !== 3) begin bad++; $display("FAIL zcal_cos_latency got=%0d want=3", lat); end
    set_beat(32'hBF12_3456, 1'b0, 1'b0, 1'b1, 1'b0, 33'h1_0000_0000);
    run_one(r, s, lat);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL zcal_sin got=%h want=80000000", r); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL zcal_sin_special got=%b want=1", s); end
    set_beat(32'hB300_0000, 1'b0, 1'b1, 1'b0, 1'b1, 33'h1_0000_0000);
    run_one(r, s, lat);
    total++; if (r !== 32'hB300_0000) begin bad++; $display("FAIL appro_sin got=%h want=b3000000", r); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL appro_sin_special got=%b want=1", s); end
  endtask

  task automatic test_normal();
    logic [31:0] r; logic s; int lat;
    set_beat(32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 33'h1_0000_0000);
    run_one(r, s, lat);
    total++; if (r !== 32'h3F80_0000) begin bad++; $display("FAIL norm_one got=%h want=3f800000", r); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL norm_one_special got=%b want=0", s); end
    total++; if (lat !== 3) begin bad++; $display("FAIL norm_latency got=%0d want=3", lat); end
    set_beat(32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 33'h0_8000_0000);
    run_one(r, s, lat);
    total++; if (r !== 32'hBF00_0000) begin bad++; $display("FAIL norm_neg_half got=%h want=bf000000", r); end
    set_beat(32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 33'h0_0000_0001);
    run_one(r, s, lat);
    total++; if (r !== 32'h2F80_0000) begin bad++; $display("FAIL norm_min_mag got=%h want=2f800000", r); end
    set_beat(32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 33'h0_0000_0000);
    run_one(r, s, lat);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL norm_zero_mag got=%h want=80000000", r); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL norm_zero_special got=%b want=0", s); end
  endtask

  task automatic test_rounding();
    logic [31:0] r; logic s; int lat;
    set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33'h0_FFFF_FFFF);
    run_one(r, s, lat);
    total++; if (r !== 32'h3F80_0000) begin bad++; $display("FAIL round_carry got=%h want=3f800000", r); end
    set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33'h1_0000_0100);
    run_one(r, s, lat);
    total++; if (r !== 32'h3F80_0000) begin bad++; $display("FAIL round_tie_even got=%h want=3f800000", r); end
    set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33'h1_0000_0300);
    run_one(r, s, lat);
    total++; if (r !== 32'h3F80_0002) begin bad++; $display("FAIL round_tie_odd got=%h want=3f800002", r); end
    set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33'h1_0000_0101);
    run_one(r, s, lat);
    total++; if (r !== 32'h3F80_0001) begin bad++; $display("FAIL round_sticky got=%h want=3f800001", r); end
    set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33'h1_0000_00FF);
    run_one(r, s, lat);
    total++; if (r !== 32'h3F80_0000) begin bad++; $display("FAIL round_down got=%h want=3f800000", r); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] bm [6];
    logic        bs [6];
    logic        bz [6];
    logic [31:0] er [6];
    logic        es [6];
    int          sent = 0;
    int          got = 0;
    logic        held = 1'b0;
    logic [31:0] held_result = 32'h0;
    bm[0] = 33'h1_0000_0000; bs[0] = 1'b0; bz[0] = 1'b0; er[0] = 32'h3F80_0000; es[0] = 1'b0;
    bm[1] = 33'h0_8000_0000; bs[1] = 1'b1; bz[1] = 1'b0; er[1] = 32'hBF00_0000; es[1] = 1'b0;
    bm[2] = 33'h0_4000_0000; bs[2] = 1'b0; bz[2] = 1'b0; er[2] = 32'h3E80_0000; es[2] = 1'b0;
    bm[3] = 33'h1_8000_0000; bs[3] = 1'b0; bz[3] = 1'b0; er[3] = 32'h3FC0_0000; es[3] = 1'b0;
    bm[4] = 33'h0_0000_0000; bs[4] = 1'b0; bz[4] = 1'b1; er[4] = 32'h3F80_0000; es[4] = 1'b1;
    bm[5] = 33'h0_0000_0000; bs[5] = 1'b1; bz[5] = 1'b0; er[5] = 32'h8000_0000; es[5] = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (sent < 6) begin
        in_valid = 1'b1;
        set_beat(32'h0, 1'b1, 1'b0, bz[sent], bs[sent], bm[sent]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (held) begin
          total++; if (result !== held_result) begin bad++; $display("FAIL b2b_hold cyc=%0d got=%h want=%h", cyc, result, held_result); end
        end
        if (out_ready) begin
          total++; if (result !== er[got]) begin bad++; $display("FAIL b2b_order beat=%0d got=%h want=%h", got, result, er[got]); end
          total++; if (special !== es[got]) begin bad++; $display("FAIL b2b_special beat=%0d got=%b want=%b", got, special, es[got]); end
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_result = result;
        end
      end
      if (cyc == 8) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b want=0", in_ready); end
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++; if (got !== 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] r; logic s; int lat;
    logic        seen = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33'h1_0000_0300 + 33'(k));
    end
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_loaded got=%b want=1", out_valid); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_ghost got=%b want=0", seen); end
    set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 33'h0_4000_0000);
    run_one(r, s, lat);
    total++; if (r !== 32'hBE80_0000) begin bad++; $display("FAIL rst_mid_next got=%h want=be800000", r); end
    total++; if (lat !== 3) begin bad++; $display("FAIL rst_mid_latency got=%0d want=3", lat); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33'h0);
    test_reset();
    test_special();
    test_normal();
    test_rounding();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
